// File: rtl/persiana_pkg.sv
// Shared types and default constants for the blind motor controller.
// Optional feature macro used by this block: SOFT_START_EN.
package persiana_pkg;

  // Motor controller states; 3 bits leave room without changing the encoding.
  typedef enum logic [2:0] {
    REPOSO   = 3'd0,
    SUBIENDO = 3'd1,
    BAJANDO  = 3'd2,
    MUERTO   = 3'd3,
    FALLO    = 3'd4
  } tipo_estado_motor;

  // Default dead time (both enables low) after leaving a drive state.
  localparam int DEAD_CYCLES_DEF    = 8;
  // Default maximum consecutive cycles in one drive state.
  localparam int TIMEOUT_CYCLES_DEF = 1000000;

endpackage

// File: rtl/controlador_motor_persiana_contador.sv
// contador_ciclos: up-counter with synchronous clear, count enable and a
// terminal-count flag. Clear has priority over enable. Wraps past all-ones.
module contador_ciclos #(
  parameter int W  = 8,
  parameter int TC = 255
) (
  input  logic reloj,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [W-1:0] TC_V = W'(TC);

  logic [W-1:0] cnt_q;

  // Counter register: reset and clear force zero, enable increments.
  always_ff @(posedge reloj) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc_o = (cnt_q == TC_V);

endmodule

// File: rtl/controlador_motor_persiana.sv
// controlador_motor_persiana: turns raw raise/lower requests into H-bridge
// enables with guaranteed dead time, mutual exclusion and a travel timeout
// that latches a fault until explicitly cleared.
// Optional feature macro: SOFT_START_EN (PWM soft start on the enables).
module controlador_motor_persiana
  import persiana_pkg::*;
#(
  parameter int DEAD_CYCLES      = DEAD_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES   = TIMEOUT_CYCLES_DEF
`ifdef SOFT_START_EN
  ,
  parameter int RAMP_STEP_CYCLES = 64
`endif
) (
  input  logic             reloj,
  input  logic             reset_n,
  input  logic             subir_req,
  input  logic             bajar_req,
  input  logic             fallo_clr,
  output logic             motor_a,
  output logic             motor_b,
  output logic             en_movimiento,
  output logic             fallo,
  output tipo_estado_motor estado_dbg
);

  localparam int RUN_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int DEAD_W = $clog2(DEAD_CYCLES) + 1;

  tipo_estado_motor estado_q;
  logic motor_a_q, motor_b_q, en_mov_q, fallo_q;

  logic sube, baja;
  logic en_subida, en_bajada, en_marcha, en_muerto;
  logic run_tc, dead_tc;
  logic drive_a, drive_b;

  // Conflicting or absent requests both decode as "stop".
  assign sube = subir_req & ~bajar_req;
  assign baja = bajar_req & ~subir_req;

  assign en_subida = (estado_q == SUBIENDO);
  assign en_bajada = (estado_q == BAJANDO);
  assign en_marcha = en_subida | en_bajada;
  assign en_muerto = (estado_q == MUERTO);

  // Run counter is held at zero outside the drive states, so it restarts
  // from zero on every entry to SUBIENDO/BAJANDO.
  contador_ciclos #(
    .W  (RUN_W),
    .TC (TIMEOUT_CYCLES - 1)
  ) u_cnt_marcha (
    .reloj   (reloj),
    .reset_n (reset_n),
    .clr_i   (~en_marcha),
    .en_i    (en_marcha),
    .tc_o    (run_tc)
  );

  // Dead counter likewise restarts from zero on every entry to MUERTO.
  contador_ciclos #(
    .W  (DEAD_W),
    .TC (DEAD_CYCLES - 1)
  ) u_cnt_muerto (
    .reloj   (reloj),
    .reset_n (reset_n),
    .clr_i   (~en_muerto),
    .en_i    (en_muerto),
    .tc_o    (dead_tc)
  );

`ifdef SOFT_START_EN
  localparam int RAMP_W = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;

  logic [3:0] duty_q;
  logic [3:0] pwm_q;
  logic       ramp_tc;

  // Ramp step timer: restarts on drive entry and after every duty step.
  contador_ciclos #(
    .W  (RAMP_W),
    .TC (RAMP_STEP_CYCLES - 1)
  ) u_cnt_rampa (
    .reloj   (reloj),
    .reset_n (reset_n),
    .clr_i   (~en_marcha | ramp_tc),
    .en_i    (en_marcha),
    .tc_o    (ramp_tc)
  );

  // Duty ramps from 0 to 15 while driving; PWM counter free-runs.
  always_ff @(posedge reloj) begin
    if (!reset_n) begin
      duty_q <= '0;
      pwm_q  <= '0;
    end else begin
      pwm_q <= pwm_q + 4'd1;
      if (!en_marcha) begin
        duty_q <= '0;
      end else if (ramp_tc && (duty_q != 4'd15)) begin
        duty_q <= duty_q + 4'd1;
      end
    end
  end

  assign drive_a = en_subida & (pwm_q < duty_q);
  assign drive_b = en_bajada & (pwm_q < duty_q);
`else
  assign drive_a = en_subida;
  assign drive_b = en_bajada;
`endif

  // Motor FSM plus Moore output registers decoded from the current state,
  // so each output lags the state by exactly one edge.
  always_ff @(posedge reloj) begin
    if (!reset_n) begin
      estado_q  <= REPOSO;
      motor_a_q <= 1'b0;
      motor_b_q <= 1'b0;
      en_mov_q  <= 1'b0;
      fallo_q   <= 1'b0;
    end else begin
      case (estado_q)
        REPOSO: begin
          if (sube) begin
            estado_q <= SUBIENDO;
          end else if (baja) begin
            estado_q <= BAJANDO;
          end
        end
        SUBIENDO: begin
          // Timeout wins over a simultaneous request change.
          if (run_tc) begin
            estado_q <= FALLO;
          end else if (!sube) begin
            estado_q <= MUERTO;
          end
        end
        BAJANDO: begin
          if (run_tc) begin
            estado_q <= FALLO;
          end else if (!baja) begin
            estado_q <= MUERTO;
          end
        end
        MUERTO: begin
          if (dead_tc) begin
            estado_q <= REPOSO;
          end
        end
        FALLO: begin
          // Only release when the upstream FSM has stopped asking to move.
          if (fallo_clr && !subir_req && !bajar_req) begin
            estado_q <= MUERTO;
          end
        end
        default: estado_q <= REPOSO;
      endcase
      motor_a_q <= drive_a;
      motor_b_q <= drive_b;
      en_mov_q  <= en_marcha;
      fallo_q   <= (estado_q == FALLO);
    end
  end

  assign motor_a       = motor_a_q;
  assign motor_b       = motor_b_q;
  assign en_movimiento = en_mov_q;
  assign fallo         = fallo_q;
  assign estado_dbg    = estado_q;

endmodule

// File: tb/tb_controlador_motor_persiana.sv
// Self-checking bench for controlador_motor_persiana (DEAD_CYCLES=4,
// TIMEOUT_CYCLES=20). Expected outputs are packed {motor_a, motor_b,
// en_movimiento, fallo} and refer to the outputs just after each edge.
module tb_controlador_motor_persiana;
  import persiana_pkg::*;

  logic reloj, reset_n, subir_req, bajar_req, fallo_clr;
  logic motor_a, motor_b, en_movimiento, fallo;
  tipo_estado_motor estado_dbg;

  controlador_motor_persiana #(
    .DEAD_CYCLES    (4),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .reloj         (reloj),
    .reset_n       (reset_n),
    .subir_req     (subir_req),
    .bajar_req     (bajar_req),
    .fallo_clr     (fallo_clr),
    .motor_a       (motor_a),
    .motor_b       (motor_b),
    .en_movimiento (en_movimiento),
    .fallo         (fallo),
    .estado_dbg    (estado_dbg)
  );

  // Clock and reset block
  initial begin
    reloj = 1'b0;
    forever #5 reloj = ~reloj;
  end

  initial begin
    reset_n   = 1'b0;
    subir_req = 1'b0;
    bajar_req = 1'b0;
    fallo_clr = 1'b0;
  end

  // Scoreboard
  logic [3:0] exp_q[$];
  string      nm_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check_outputs();
    logic [3:0] e;
    logic [3:0] got;
    string      nm;
    e   = exp_q.pop_front();
    nm  = nm_q.pop_front();
    got = {motor_a, motor_b, en_movimiento, fallo};
    n_tests++;
    if (got !== e || (motor_a & motor_b) !== 1'b0) begin
      n_fail++;
      $display("FAIL %s t=%0t got {a,b,mov,fallo}=%b expected %b", nm, $time, got, e);
    end
  endtask

  // Driver: apply one cycle of inputs, queue the expectation, sample #1
  // after the edge.
  task automatic step(input logic rst, input logic s, input logic b,
                      input logic c, input logic [3:0] e, input string nm);
    reset_n   = rst;
    subir_req = s;
    bajar_req = b;
    fallo_clr = c;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge reloj);
    #1;
    check_outputs();
  endtask

  typedef struct {
    string      nm;
    logic       rst_n;
    logic       s;
    logic       b;
    logic       c;
    logic [3:0] e;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string nm, input logic r, input logic s,
                              input logic b, input logic c, input logic [3:0] e);
    vec_t v;
    v.nm = nm; v.rst_n = r; v.s = s; v.b = b; v.c = c; v.e = e;
    return v;
  endfunction

  initial begin
    // Reset
    vecs.push_back(mk("reset",        1'b0, 1'b0, 1'b0, 1'b0, 4'b0000));
    vecs.push_back(mk("reset",        1'b0, 1'b0, 1'b0, 1'b0, 4'b0000));
    // Raise: enable appears on the second edge after the request
    vecs.push_back(mk("raise_lat",    1'b1, 1'b1, 1'b0, 1'b0, 4'b0000));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk("raise_on",   1'b1, 1'b1, 1'b0, 1'b0, 4'b1010));
    // Reversal: one more drive cycle, then DEAD+1 cycles of both low
    vecs.push_back(mk("rev_lat",      1'b1, 1'b0, 1'b1, 1'b0, 4'b1010));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk("rev_gap",    1'b1, 1'b0, 1'b1, 1'b0, 4'b0000));
    for (int i = 0; i < 2; i++)
      vecs.push_back(mk("lower_on",   1'b1, 1'b0, 1'b1, 1'b0, 4'b0110));
    // Reset during BAJANDO drops the enable at that same edge
    vecs.push_back(mk("rst_mid",      1'b0, 1'b0, 1'b1, 1'b0, 4'b0000));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk("idle_post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000));
    // Conflicting requests never move the motor
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk("both_req",   1'b1, 1'b1, 1'b1, 1'b0, 4'b0000));
    vecs.push_back(mk("release",      1'b1, 1'b0, 1'b0, 1'b0, 4'b0000));
    // Short lower then stop; a raise request during MUERTO is ignored
    vecs.push_back(mk("short_lower",  1'b1, 1'b0, 1'b1, 1'b0, 4'b0000));
    vecs.push_back(mk("short_lower",  1'b1, 1'b0, 1'b1, 1'b0, 4'b0110));
    vecs.push_back(mk("stop_lat",     1'b1, 1'b0, 1'b0, 1'b0, 4'b0110));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk("dead_ignore", 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000));
    // dead ends, REPOSO sees raise, SUBIENDO, then output
    vecs.push_back(mk("dead_ignore",  1'b1, 1'b1, 1'b0, 1'b0, 4'b0000));
    vecs.push_back(mk("after_dead",   1'b1, 1'b1, 1'b0, 1'b0, 4'b0000));
    vecs.push_back(mk("after_dead",   1'b1, 1'b1, 1'b0, 1'b0, 4'b1010));
    vecs.push_back(mk("stop_lat",     1'b1, 1'b0, 1'b0, 1'b0, 4'b1010));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk("idle",       1'b1, 1'b0, 1'b0, 1'b0, 4'b0000));

    @(negedge reloj);
    foreach (vecs[i])
      step(vecs[i].rst_n, vecs[i].s, vecs[i].b, vecs[i].c, vecs[i].e, vecs[i].nm);

    // Timeout: raise held 25 cycles; FALLO entered on edge 20, seen on 21
    for (int j = 0; j < 25; j++) begin
      if (j == 0)
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, "to_lat");
      else if (j <= 20)
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'b1010, "to_drive");
      else
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, "to_fault");
    end
    // Clear refused while a request is still high
    for (int j = 0; j < 2; j++)
      step(1'b1, 1'b1, 1'b0, 1'b1, 4'b0001, "clr_with_req");
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'b0001, "clr_with_lower");
    // Accepted clear: FALLO -> MUERTO (4 cycles) -> REPOSO -> SUBIENDO
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, "clr_accept");
    for (int j = 0; j < 5; j++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, "fault_dead");
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'b1010, "fault_recover");
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b1010, "final_stop_lat");
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, "final_stop");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
